// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: LIFO stack storage with a valid/ready request/response port.
// Tracks the byte-address stack pointer. It reports full/empty and rejects overflow/underflow.
module stack_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int BASE   = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_push,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic [31:0]              sp_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [31:0]   BASE_C  = 32'(BASE);
  localparam logic [31:0]   STEP_C  = 32'd4;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  state_t            state_q;
  logic [31:0]       sp_q;
  logic [CW-1:0]     cnt_q;
  logic              full_q;
  logic              empty_q;
  logic              rdy_q;
  logic              vld_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic          accept;
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;

  // Requests are never taken while reset is held, even though ready is 1.
  assign accept  = rst & req_valid & rdy_q;
  assign do_push = accept & req_push & ~full_q;
  assign do_pop  = accept & ~req_push & ~empty_q;

  // Entry index equals count: next free slot for writes, top of stack for reads.
  assign widx = cnt_q[AW-1:0];
  assign ridx = cnt_q[AW-1:0] - ONE_A;

  // Storage write and registered top-of-stack read; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[widx] <= req_data;
    if (do_pop)  rd_q        <= mem_q[ridx];
  end

  // Control FSM with registered pointer, flags and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sp_q    <= BASE_C;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            rdy_q <= 1'b0;
            unique case (1'b1)
              do_push: begin
                sp_q    <= sp_q + STEP_C;
                cnt_q   <= cnt_q + ONE_C;
                full_q  <= (cnt_q == DEPTH_C - ONE_C);
                empty_q <= 1'b0;
                data_q  <= req_data;
                err_q   <= 1'b0;
                vld_q   <= 1'b1;
                state_q <= RESP;
              end
              do_pop: begin
                sp_q    <= sp_q - STEP_C;
                cnt_q   <= cnt_q - ONE_C;
                full_q  <= 1'b0;
                empty_q <= (cnt_q == ONE_C);
                state_q <= READ;
              end
              default: begin
                data_q  <= '0;
                err_q   <= 1'b1;
                vld_q   <= 1'b1;
                state_q <= RESP;
              end
            endcase
          end
        end
        READ: begin
          data_q  <= rd_q;
          err_q   <= 1'b0;
          vld_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          err_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign sp_out    = sp_q;
  assign count     = cnt_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// tb_stack_mem_ctrl: directed stimulus, queue-based reference model,
// per-cycle compare plus hand-computed literal expectations.
module tb_stack_mem_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_push = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [31:0]   sp_out;
  logic [6:0]    count;
  logic          full;
  logic          empty;

  stack_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .BASE(512)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_push(req_push), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sp_out(sp_out), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of live words plus one pending response.
  logic [31:0] q[$];
  bit          m_rv = 1'b0;
  bit          m_err = 1'b0;
  bit          m_wait = 1'b0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rv = 1'b0;
      m_err = 1'b0;
      m_wait = 1'b0;
      m_rd = '0;
    end else if (m_rv) begin
      if (rsp_ready) begin
        m_rv = 1'b0;
        m_err = 1'b0;
      end
    end else if (m_wait) begin
      m_wait = 1'b0;
      m_rv = 1'b1;
      m_err = 1'b0;
      m_rd = m_pend;
    end else if (req_valid) begin
      if (req_push) begin
        if (q.size() == DEPTH) begin
          m_err = 1'b1; m_rd = '0; m_rv = 1'b1;
        end else begin
          q.push_back(req_data);
          m_err = 1'b0; m_rd = req_data; m_rv = 1'b1;
        end
      end else begin
        if (q.size() == 0) begin
          m_err = 1'b1; m_rd = '0; m_rv = 1'b1;
        end else begin
          m_pend = q.pop_back();
          m_wait = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_sp", 64'(sp_out), 64'(512 + 4 * q.size()));
    check("m_count", 64'(count), 64'(q.size()));
    check("m_full", 64'(full), 64'(q.size() == DEPTH));
    check("m_empty", 64'(empty), 64'(q.size() == 0));
    check("m_req_ready", 64'(req_ready), 64'(!m_rv && !m_wait));
    check("m_rsp_valid", 64'(rsp_valid), 64'(m_rv));
    check("m_rsp_err", 64'(rsp_err), 64'(m_err));
    check("m_rsp_data", 64'(rsp_data), 64'(m_rd));
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One request with rsp_ready=1; lat = edges from acceptance to handshake.
  task automatic xact(input bit push, input logic [31:0] d,
                      output logic [31:0] rd, output logic err,
                      output int lat);
    req_valid = 1'b1;
    req_push  = push;
    req_data  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = '0;
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_seen", 64'(rsp_valid), 64'd1);
    rd  = rsp_data;
    err = rsp_err;
    @(posedge clk);
    #1;
    lat++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [31:0] pv [3];
    logic [31:0] spv [3];
    pv  = '{32'hA, 32'hB, 32'hC};
    spv = '{32'd516, 32'd520, 32'd524};

    #2;
    do_reset();
    check("rst_sp", 64'(sp_out), 64'd512);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);

    for (int i = 0; i < 3; i++) begin
      xact(1'b1, pv[i], rd, err, lat);
      check("lifo_push_data", 64'(rd), 64'(pv[i]));
      check("lifo_push_err", 64'(err), 64'd0);
      check("lifo_push_lat", 64'(lat), 64'd1);
      check("lifo_push_sp", 64'(sp_out), 64'(spv[i]));
    end
    for (int i = 2; i >= 0; i--) begin
      xact(1'b0, 32'h0, rd, err, lat);
      check("lifo_pop_data", 64'(rd), 64'(pv[i]));
      check("lifo_pop_err", 64'(err), 64'd0);
      check("lifo_pop_lat", 64'(lat), 64'd2);
      check("lifo_pop_sp", 64'(sp_out), 64'(512 + 4 * i));
    end

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b1, 32'h1000 + 32'(i), rd, err, lat);
    end
    check("full_sp", 64'(sp_out), 64'd768);
    check("full_flag", 64'(full), 64'd1);
    check("full_count", 64'(count), 64'd64);
    xact(1'b1, 32'hDEAD, rd, err, lat);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_data", 64'(rd), 64'd0);
    check("ovf_lat", 64'(lat), 64'd1);
    check("ovf_sp", 64'(sp_out), 64'd768);
    xact(1'b0, 32'h0, rd, err, lat);
    check("full_pop_data", 64'(rd), 64'h103F);
    check("full_pop_err", 64'(err), 64'd0);
    check("full_pop_sp", 64'(sp_out), 64'd764);
    check("full_pop_full", 64'(full), 64'd0);

    do_reset();
    xact(1'b0, 32'h0, rd, err, lat);
    check("udf_err", 64'(err), 64'd1);
    check("udf_data", 64'(rd), 64'd0);
    check("udf_lat", 64'(lat), 64'd1);
    check("udf_sp", 64'(sp_out), 64'd512);
    check("udf_empty", 64'(empty), 64'd1);
    xact(1'b1, 32'h5, rd, err, lat);
    xact(1'b0, 32'h0, rd, err, lat);
    check("udf_pop5_data", 64'(rd), 64'h5);
    check("udf_pop5_err", 64'(err), 64'd0);

    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_push  = 1'b1;
    req_data  = 32'h77;
    @(posedge clk);
    #1;
    req_data = 32'h99;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_data", 64'(rsp_data), 64'h77);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_sp", 64'(sp_out), 64'd516);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_data  = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_ready", 64'(req_ready), 64'd1);
    check("bp_idle_valid", 64'(rsp_valid), 64'd0);
    check("bp_idle_sp", 64'(sp_out), 64'd516);
    xact(1'b0, 32'h0, rd, err, lat);
    check("bp_pop_data", 64'(rd), 64'h77);

    do_reset();
    xact(1'b1, 32'h1, rd, err, lat);
    xact(1'b1, 32'h2, rd, err, lat);
    req_valid = 1'b1;
    req_push  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    check("ar_sp", 64'(sp_out), 64'd512);
    check("ar_count", 64'(count), 64'd0);
    check("ar_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ar_no_stale", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    xact(1'b0, 32'h0, rd, err, lat);
    check("ar_pop_err", 64'(err), 64'd1);
    check("ar_pop_data", 64'(rd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_mem_ctrl.md
# stack_mem_ctrl

Data-side partner of the stack pointer: owns the stack storage and serves push/pop requests from the control unit with a valid/ready handshake. It keeps the byte-address stack pointer internally, using the codebase convention: base 512, grows upward by 4 per push. It writes pushed words, returns popped words in LIFO order, and reports full, empty, overflow and underflow. It sits between the control unit and the datapath's call/return and PUSH/POP paths.

## Interface
- DATA_W, 32, width of a stack word
- DEPTH, 64, number of stack entries (power of two)
- BASE, 512, byte address of entry 0; byte stride is 4
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_push  input  1  1 = push, 0 = pop (same encoding as stack_sig)
- req_data  input  DATA_W  word to push; ignored on pop
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  DATA_W  popped word (pop) or echoed pushed word (push); 0 on error
- rsp_err  output  1  request rejected (overflow or underflow)
- sp_out  output  32  byte address of the next free slot
- count  output  log2(DEPTH)+1  entries held
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Storage: DEPTH x DATA_W array. Index = (sp - BASE) >> 2. Memory contents are not cleared by reset.
- Reset (rst=0, async) drives: state IDLE, sp_out=BASE (512), count=0, empty=1, full=0, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0.
- A request is accepted on a rising edge when req_valid=1 and req_ready=1. req_ready is 1 only in IDLE.
- FSM states: IDLE, READ, RESP.
- IDLE, push accepted, not full:
  - mem[index(sp)] <= req_data
  - sp += 4
  - rsp_data <= req_data, rsp_err <= 0
  - next state RESP
- IDLE, pop accepted, not empty:
  - sp -= 4
  - launch a registered read of mem[index(sp-4)]
  - next state READ
- READ: rsp_data <= read word, rsp_err <= 0; next state RESP.
- IDLE, push when full, or pop when empty:
  - no memory write, sp unchanged
  - rsp_err <= 1, rsp_data <= 0
  - next state RESP
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable.
  - On rsp_valid and rsp_ready, return to IDLE and clear rsp_valid and rsp_err.
  - rsp_data keeps its last value.
- sp_out, count, full and empty are registered. They update on the same edge that accepts the request.
- Arithmetic:
  - sp is 32-bit unsigned; it only ever takes values BASE .. BASE+4*DEPTH (512..768).
  - count = (sp - BASE) >> 2.
  - sp never wraps; out-of-range requests are errors, not wrap-arounds.

## Timing
- Push latency: accepted at edge k; rsp_valid=1 from edge k. The earliest response handshake is edge k+1.
- Pop latency: accepted at edge k; READ during k..k+1; rsp_valid=1 from edge k+1. The earliest response handshake is edge k+2.
- Error latency: same as push (one cycle).
- Throughput with rsp_ready tied to 1: one push every 2 cycles, one pop every 3 cycles.
- Back-pressure: while rsp_ready=0, the block stays in RESP with all outputs frozen; req_ready stays 0.
- Mid-operation reset: asserting rst in any state returns to the reset values immediately, without waiting for clk.
  - A pending response is dropped.
  - A push accepted on the edge before reset leaves memory written, but sp returns to 512.
- Reset deassertion is synchronized by the integrator. The first request can be accepted on the first edge after rst=1.

## Test plan
- Reset: hold rst=0, then release.
  - Required: sp_out=512, count=0, empty=1, full=0, req_ready=1, rsp_valid=0.
- LIFO order: push 0xA, 0xB, 0xC, then pop three times with rsp_ready=1.
  - Required: rsp_data 0xC, 0xB, 0xA.
  - sp_out steps 512->516->520->524, then 520->516->512.
  - Push responses arrive 1 cycle after acceptance; pop responses arrive 2 cycles after acceptance.
- Full boundary: push 64 distinct words.
  - Required: sp_out=768, full=1, count=64.
  - A 65th push then returns rsp_err=1, rsp_data=0, and sp_out stays 768.
  - A following pop returns the 64th word with sp_out=764.
- Empty boundary: pop after reset.
  - Required: rsp_err=1, rsp_data=0, sp_out=512, empty=1.
  - A following push of 0x5 then a pop returns 0x5.
- Back-pressure: push 0x77 with rsp_ready=0 for 5 cycles.
  - Required: rsp_valid=1, rsp_data=0x77 and req_ready=0 for all 5 cycles.
  - A new req_valid is not accepted; after rsp_ready=1, the block is in IDLE the next cycle.
- Async reset mid-READ: push 0x1 and 0x2, issue a pop, and drive rst=0 between clock edges during READ.
  - Required: rsp_valid=0 and sp_out=512 immediately, before the next edge.
  - No stale response appears after rst returns to 1.
